// File: rtl/ifetch_prefetch_pkg.sv
// ifetch_prefetch_pkg
//   Constants shared by the instruction prefetcher, its queue and its bus
//   interface.
//   RESET_PC_DEFAULT : default first fetch address after reset
//   INSTR_W          : instruction word width in bits
//   INSTR_BYTES      : instruction width in bytes (the sequential PC step)
package ifetch_prefetch_pkg;

  localparam int unsigned INSTR_W          = 32;
  localparam int unsigned INSTR_BYTES      = INSTR_W / 8;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/ifetch_prefetch_if.sv
// ifetch_prefetch_if
//   Bundles the ROM read bus, the redirect request and the instruction
//   stream handshake of the prefetcher.
//   master : the prefetcher (drives ROM address/read and the instruction head)
//   slave  : its surroundings (ROM data, redirect, consumer ready)
interface ifetch_prefetch_if #(
  parameter int ADDR_W = 32,
  parameter int ROM_AW = 14
);
  import ifetch_prefetch_pkg::*;

  logic                rom_rd_o;
  logic [ROM_AW-1:0]   rom_adr_o;
  logic [INSTR_W-1:0]  rom_data_i;
  logic                redirect_i;
  logic [ADDR_W-1:0]   redirect_pc_i;
  logic                instr_valid_o;
  logic                instr_ready_i;
  logic [INSTR_W-1:0]  instr_o;
  logic [ADDR_W-1:0]   pc_o;
  logic [ADDR_W-1:0]   pc_plus4_o;

  modport master (
    output rom_rd_o, rom_adr_o, instr_valid_o, instr_o, pc_o, pc_plus4_o,
    input  rom_data_i, redirect_i, redirect_pc_i, instr_ready_i
  );

  modport slave (
    input  rom_rd_o, rom_adr_o, instr_valid_o, instr_o, pc_o, pc_plus4_o,
    output rom_data_i, redirect_i, redirect_pc_i, instr_ready_i
  );

endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue
//   Small FIFO holding fetched {instruction, pc} entries.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   i_push       : write i_wdata at the tail (caller never pushes when full
//                  without a simultaneous pop)
//   i_pop        : drop the head (ignored when empty)
//   i_flush      : empty the queue; overrides push and pop
//   o_rdata      : head entry, zero when empty
//   o_full, o_empty, o_count : occupancy status
module ifetch_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [W-1:0]               i_wdata,
  output logic [W-1:0]               o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_pop;

  assign w_pop   = i_pop & ~o_empty;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
  assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

  // DEPTH is a power of two, so plain increments wrap the pointers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage has no reset; stale contents are never visible because the
  // head is masked to zero whenever the queue is empty.
  always_ff @(posedge clock) begin
    if (i_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/ifetch_prefetch.sv
// ifetch_prefetch
//   Instruction prefetcher: issues sequential ROM reads, queues the returned
//   words with their PCs and presents them over a valid/ready handshake.
//   A redirect flushes the queue, drops any in-flight response and restarts
//   fetching at the target.
//   clock : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : ifetch_prefetch_if.master (ROM bus, redirect, instruction stream)
module ifetch_prefetch
  import ifetch_prefetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                ROM_AW   = 14,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic               clock,
  input  logic               reset,
  ifetch_prefetch_if.master  bus
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = INSTR_W + ADDR_W;

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_inflight_pc;
  logic              r_inflight;

  logic              w_deq;
  logic              w_issue;
  logic              w_push;
  logic              w_empty;
  logic              w_full;
  logic [CW-1:0]     w_count;
  logic [CW:0]       w_occ;
  logic [EW-1:0]     w_head;
  logic              w_unused;

  assign w_unused = &{1'b0, bus.redirect_pc_i[1:0]};

  assign bus.instr_valid_o = ~w_empty;
  assign w_deq = bus.instr_valid_o & bus.instr_ready_i;

  // Slots committed after this edge: queued entries, minus the one leaving,
  // plus the response already on its way. Issue only if one stays free.
  assign w_occ   = {1'b0, w_count} - (CW+1)'(w_deq) + (CW+1)'(r_inflight);
  assign w_issue = ~reset & ~bus.redirect_i & (w_occ < (CW+1)'(DEPTH));

  // A response landing in a redirect cycle belongs to the old path.
  assign w_push = r_inflight & ~bus.redirect_i & (~w_full | w_deq);

  assign bus.rom_rd_o  = w_issue;
  assign bus.rom_adr_o = r_fetch_pc[ROM_AW+1:2];

  // NOTE: non-blocking assignments so every register samples pre-edge values
  // and the update order inside the block does not matter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_inflight_pc <= r_fetch_pc;
      if (bus.redirect_i)
        r_fetch_pc <= {bus.redirect_pc_i[ADDR_W-1:2], 2'b00};
      else if (w_issue)
        r_fetch_pc <= r_fetch_pc + ADDR_W'(INSTR_BYTES);
    end
  end

  ifetch_queue #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_queue (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_deq),
    .i_flush (bus.redirect_i),
    .i_wdata ({bus.rom_data_i, r_inflight_pc}),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign bus.instr_o    = w_head[EW-1:ADDR_W];
  assign bus.pc_o       = w_head[ADDR_W-1:0];
  assign bus.pc_plus4_o = w_empty ? '0 : w_head[ADDR_W-1:0] + ADDR_W'(INSTR_BYTES);

endmodule

// File: tb/tb_ifetch_prefetch.sv
// tb_ifetch_prefetch
//   Directed bench for ifetch_prefetch (ADDR_W=32, ROM_AW=14, DEPTH=4,
//   RESET_PC=0). The ROM model returns word i = 0x1000_0000+i one cycle after
//   a read and 0xDEAD_BEEF in cycles with no outstanding read.
module tb_ifetch_prefetch;

  logic clock = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clock = ~clock;

  ifetch_prefetch_if #(.ADDR_W(32), .ROM_AW(14)) bus ();

  ifetch_prefetch #(
    .ADDR_W   (32),
    .ROM_AW   (14),
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic        r_rd = 1'b0;
  logic [13:0] r_adr = '0;
  always @(posedge clock) begin
    r_rd  <= bus.rom_rd_o;
    r_adr <= bus.rom_adr_o;
  end
  assign bus.rom_data_i = r_rd ? (32'h1000_0000 + {18'h0, r_adr}) : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;
    bus.instr_ready_i = 1'b1;
    tick(); tick();
    check("rst_valid", 64'(bus.instr_valid_o), 64'h0);
    check("rst_rd",    64'(bus.rom_rd_o),      64'h0);
    check("rst_instr", 64'(bus.instr_o),       64'h0);
    check("rst_pc",    64'(bus.pc_o),          64'h0);
    check("rst_pc4",   64'(bus.pc_plus4_o),    64'h0);

    // Streaming from reset release with ready held high.
    reset = 1'b0;
    #1;
    check("c0_rd",  64'(bus.rom_rd_o),  64'h1);
    check("c0_adr", 64'(bus.rom_adr_o), 64'h0);
    tick();
    check("c1_nobypass", 64'(bus.instr_valid_o), 64'h0);
    for (int k = 2; k < 8; k++) begin
      tick();
      check("seq_valid", 64'(bus.instr_valid_o), 64'h1);
      check("seq_pc",    64'(bus.pc_o),          64'(4 * (k - 2)));
      check("seq_instr", 64'(bus.instr_o),       64'(32'h1000_0000 + (k - 2)));
      check("seq_pc4",   64'(bus.pc_plus4_o),    64'(4 * (k - 1)));
    end

    // Stall to 3 queued entries, then reset mid-stream.
    bus.instr_ready_i = 1'b0;
    tick(); tick();
    check("stall_hold_pc", 64'(bus.pc_o), 64'h14);
    reset = 1'b1;
    #1;
    check("midrst_valid", 64'(bus.instr_valid_o), 64'h0);
    check("midrst_rd",    64'(bus.rom_rd_o),      64'h0);
    check("midrst_pc",    64'(bus.pc_o),          64'h0);
    tick(); tick();

    // Release with ready low: queue fills to DEPTH and fetching stops.
    reset = 1'b0;
    #1;
    check("r2_c0_rd",  64'(bus.rom_rd_o),  64'h1);
    check("r2_c0_adr", 64'(bus.rom_adr_o), 64'h0);
    tick(); tick();
    check("r2_first_valid", 64'(bus.instr_valid_o), 64'h1);
    check("r2_first_pc",    64'(bus.pc_o),          64'h0);
    tick(); tick();
    for (int k = 5; k < 10; k++) begin
      tick();
      check("full_rd",    64'(bus.rom_rd_o),      64'h0);
      check("full_valid", 64'(bus.instr_valid_o), 64'h1);
      check("full_pc",    64'(bus.pc_o),          64'h0);
      check("full_instr", 64'(bus.instr_o),       64'h1000_0000);
    end
    tick();
    bus.instr_ready_i = 1'b1;
    for (int k = 10; k < 18; k++) begin
      check("resume_valid", 64'(bus.instr_valid_o), 64'h1);
      check("resume_pc",    64'(bus.pc_o),          64'(4 * (k - 10)));
      check("resume_instr", 64'(bus.instr_o),       64'(32'h1000_0000 + (k - 10)));
      tick();
    end

    // Redirect to 0x43 while the queue is full.
    bus.instr_ready_i = 1'b0;
    repeat (6) tick();
    check("pre_redir_rd", 64'(bus.rom_rd_o), 64'h0);
    check("pre_redir_pc", 64'(bus.pc_o),     64'h20);
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h0000_0043;
    #1;
    check("redir_no_issue", 64'(bus.rom_rd_o), 64'h0);
    tick();
    bus.redirect_i    = 1'b0;
    bus.instr_ready_i = 1'b1;
    #1;
    check("redir_t1_valid", 64'(bus.instr_valid_o), 64'h0);
    check("redir_t1_rd",    64'(bus.rom_rd_o),      64'h1);
    check("redir_t1_adr",   64'(bus.rom_adr_o),     64'h10);
    tick();
    check("redir_t2_valid", 64'(bus.instr_valid_o), 64'h0);
    tick();
    check("redir_t3_valid", 64'(bus.instr_valid_o), 64'h1);
    check("redir_t3_pc",    64'(bus.pc_o),          64'h40);
    check("redir_t3_instr", 64'(bus.instr_o),       64'h1000_0010);
    check("redir_t3_pc4",   64'(bus.pc_plus4_o),    64'h44);
    tick();
    check("redir_t4_pc",    64'(bus.pc_o),          64'h44);

    // Redirect coinciding with a dequeue and an in-flight response.
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h0000_0200;
    #1;
    check("stale_no_issue", 64'(bus.rom_rd_o), 64'h0);
    tick();
    bus.redirect_i = 1'b0;
    #1;
    check("stale_u1_valid", 64'(bus.instr_valid_o), 64'h0);
    check("stale_u1_instr", 64'(bus.instr_o),       64'h0);
    tick();
    check("stale_u2_valid", 64'(bus.instr_valid_o), 64'h0);
    check("stale_u2_instr", 64'(bus.instr_o),       64'h0);
    tick();
    check("stale_u3_pc",    64'(bus.pc_o),    64'h200);
    check("stale_u3_instr", 64'(bus.instr_o), 64'h1000_0080);
    tick();
    check("stale_u4_pc",    64'(bus.pc_o),    64'h204);
    check("stale_u4_instr", 64'(bus.instr_o), 64'h1000_0081);

    // PC wrap at the top of the address space.
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    bus.redirect_i = 1'b0;
    #1;
    check("wrap_adr_top", 64'(bus.rom_adr_o), 64'h3FFF);
    check("wrap_rd",      64'(bus.rom_rd_o),  64'h1);
    tick();
    check("wrap_adr_zero", 64'(bus.rom_adr_o), 64'h0);
    tick();
    check("wrap_pc_top",   64'(bus.pc_o),       64'hFFFF_FFFC);
    check("wrap_pc4",      64'(bus.pc_plus4_o), 64'h0);
    check("wrap_instr",    64'(bus.instr_o),    64'h1000_3FFF);
    tick();
    check("wrap_pc_next",  64'(bus.pc_o),       64'h0);
    check("wrap_instr_nx", 64'(bus.instr_o),    64'h1000_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_prefetch.md
IFETCH_PREFETCH -- requirements
Module: ifetch_prefetch

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning PC width in bits.
REQ-002 The block SHALL have parameter ROM_AW, default 14, meaning instruction-ROM word-address width.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning prefetch-queue entries; power of two, at least 2.
REQ-004 The block SHALL have parameter RESET_PC, default 0, meaning the first fetch address after reset; word aligned.
REQ-005 The block SHALL have port clock, input, 1, meaning the system clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, meaning reset, asynchronous, active-high.
REQ-007 The block SHALL have port rom_rd_o, output, 1, meaning a ROM read is issued this cycle.
REQ-008 The block SHALL have port rom_adr_o, output, ROM_AW, meaning ROM word address, equal to fetch_pc[ROM_AW+1:2].
REQ-009 The block SHALL have port rom_data_i, input, 32, meaning ROM data, valid exactly one cycle after rom_rd_o.
REQ-010 The block SHALL have port redirect_i, input, 1, meaning taken branch, j, jal or jr this cycle.
REQ-011 The block SHALL have port redirect_pc_i, input, ADDR_W, meaning the redirect target; bits [1:0] are ignored and treated as 0.
REQ-012 The block SHALL have port instr_valid_o, output, 1, meaning the queue head is valid.
REQ-013 The block SHALL have port instr_ready_i, input, 1, meaning the consumer accepts the head.
REQ-014 The block SHALL have port instr_o, output, 32, meaning the head instruction word.
REQ-015 The block SHALL have port pc_o, output, ADDR_W, meaning the head instruction's PC.
REQ-016 The block SHALL have port pc_plus4_o, output, ADDR_W, meaning pc_o+4, used as branch base and link address.

Function
REQ-017 The block SHALL hold fetch_pc, the next address to fetch; fetch_pc SHALL advance by 4 on every issue, modulo 2^ADDR_W.
REQ-018 The block SHALL count occupancy count (0..DEPTH) and inflight (0/1); deq SHALL equal instr_valid_o AND instr_ready_i.
REQ-019 The block SHALL drive rom_rd_o high iff redirect_i=0 and (count - deq + inflight) < DEPTH, giving a sustained rate of 1 instruction/cycle while ready is held high.
REQ-020 Each non-discarded ROM response SHALL be enqueued at the end of its response cycle together with its fetch PC; instr_valid_o SHALL rise no earlier than the following cycle (no bypass).
REQ-021 The queue SHALL be first-in first-out; instr_o, pc_o and pc_plus4_o SHALL hold stable while instr_valid_o=1 and instr_ready_i=0.
REQ-022 When redirect_i=1 in cycle t, the block SHALL at the t edge empty the queue, set fetch_pc to {redirect_pc_i[ADDR_W-1:2],2'b00}, issue nothing in t, and discard any response arriving in cycle t+1.
REQ-023 After a redirect in cycle t, the block SHALL issue the target at t+1 and present it with instr_valid_o=1 at t+3.
REQ-024 When redirect_i and deq coincide, the redirect SHALL win and the dequeue SHALL have no further effect.
REQ-025 When enqueue and dequeue coincide while the queue is full, both SHALL occur and count SHALL be unchanged; enqueue into a full queue SHALL never occur.
REQ-026 Queue read/write pointers SHALL wrap modulo DEPTH.
REQ-027 When count=0, instr_valid_o SHALL be 0, and instr_ready_i SHALL be ignored.

Reset
REQ-028 While reset=1, the block SHALL force fetch_pc=RESET_PC, count=0, inflight=0, pointers=0, instr_valid_o=0, rom_rd_o=0, and instr_o, pc_o and pc_plus4_o to 0.
REQ-029 A ROM response arriving in the cycle after reset deasserts SHALL be discarded; the first issue SHALL be RESET_PC in the first cycle after deassertion.
REQ-030 Reset asserted mid-operation SHALL abandon all queued and in-flight fetches.

Structure
REQ-031 A shared package SHALL define RESET_PC_DEFAULT, INSTR_W=32 and the instruction-width constant; the block SHALL add nothing else to it.
REQ-032 The queue SHALL be a sub-module ifetch_queue, parametrised by DEPTH and entry width (32+ADDR_W), with push, pop, flush, full, empty and count.

Verification
REQ-033 The bench SHALL check: reset release with ready=1 and a ROM holding word i = 0x1000_0000+i -> pc_o values 0,4,8,... on consecutive cycles from cycle 2, one per cycle.
REQ-034 The bench SHALL check: ready=0 for 10 cycles -> count saturates at DEPTH=4, rom_rd_o=0, the head holds PC 0x0; on ready=1 the sequence continues without gap or duplicate.
REQ-035 The bench SHALL check: redirect_i=1 with target 0x0000_0043 while the queue is full -> the queue is empties the next cycle, rom_adr_o=0x10 at t+1, and pc_o=0x40 with instr_valid_o=1 at t+3.
REQ-036 The bench SHALL check: redirect coinciding with deq and an in-flight response -> the stale word never appears on instr_o.
REQ-037 The bench SHALL check: fetch_pc=0xFFFF_FFFC with ADDR_W=32 -> the next PC is 0x0000_0000.
REQ-038 The bench SHALL check: reset pulsed mid-stream with 3 entries queued -> instr_valid_o=0 immediately, and the first post-reset pc_o equals RESET_PC.
